// File: rtl/pipeline_mem_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 access widths and the access FSM states.
package pipeline_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (f3)
            F3_H, F3_HU: r = off[0];
            F3_W:        r = |off;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipeline_mem_stage_align.sv
// Byte-lane steering: store strobes/replicated data from the live instruction,
// load field extraction and sign/zero extension from the returned word.
module pipeline_mem_stage_align
    import pipeline_mem_stage_pkg::*;
(
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] rs2,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wstrb = 4'b1111;
        wdata = rs2;
        case (st_f3)
            F3_B, F3_BU: begin
                wstrb = 4'b0001 << st_off;
                wdata = {4{rs2[7:0]}};
            end
            F3_H, F3_HU: begin
                wstrb = 4'b0011 << {st_off[1], 1'b0};
                wdata = {2{rs2[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = rdata[{ld_off, 3'b000} +: 8];
    assign half_sel = rdata[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = rdata;
        case (ld_f3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM stage: runs one data-memory access per instruction over a valid/ready port,
// stalling upstream until it completes, and resolves the branch decision.
module pipeline_mem_stage
    import pipeline_mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in_MEM,
    input  logic [ADDR_W-1:0]   ALU_out_in_MEM,
    input  logic [DATA_W-1:0]   Rs2_in_MEM,
    input  logic                MemRead_in_MEM,
    input  logic                MemWrite_in_MEM,
    input  logic [2:0]          funct3_in_MEM,
    input  logic                Branch_in_MEM,
    input  logic                zero_in_MEM,
    output logic                PCSrc_out_MEM,
    output logic                stall_out_MEM,
    output logic                valid_out_MEM,
    output logic [DATA_W-1:0]   Data_out_MEM,
    output logic [ADDR_W-1:0]   ALU_out_out_MEM,
    output logic                misalign_out_MEM,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic                dmem_we,
    output logic [DATA_W/8-1:0] dmem_wstrb,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_rsp_valid,
    input  logic [DATA_W-1:0]   dmem_rdata
);

    mem_state_e state, state_nxt;

    logic                mem_op, misaligned, mem_go;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, data_q, wdata_c, ld_data;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_c;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;

    assign mem_op     = valid_in_MEM & (MemRead_in_MEM | MemWrite_in_MEM);
    assign misaligned = is_misaligned(funct3_in_MEM, ALU_out_in_MEM[1:0]);
    assign mem_go     = mem_op & ~misaligned;

    pipeline_mem_stage_align u_align (
        .st_f3   (funct3_in_MEM),
        .st_off  (ALU_out_in_MEM[1:0]),
        .rs2     (Rs2_in_MEM),
        .wstrb   (wstrb_c),
        .wdata   (wdata_c),
        .ld_f3   (f3_q),
        .ld_off  (off_q),
        .rdata   (dmem_rdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mem_go)         state_nxt = ST_REQ;
            ST_REQ:  if (dmem_req_ready) state_nxt = we_q ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem_rsp_valid) state_nxt = ST_DONE;
            ST_DONE:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Request payload is captured once in IDLE so it stays stable across a stalled REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            data_q  <= '0;
        end else begin
            if (state == ST_IDLE && mem_go) begin
                addr_q  <= {ALU_out_in_MEM[ADDR_W-1:2], 2'b00};
                wdata_q <= MemWrite_in_MEM ? wdata_c : '0;
                wstrb_q <= MemWrite_in_MEM ? wstrb_c : '0;
                we_q    <= MemWrite_in_MEM;
                f3_q    <= funct3_in_MEM;
                off_q   <= ALU_out_in_MEM[1:0];
            end
            if (state == ST_WAIT && dmem_rsp_valid)
                data_q <= ld_data;
        end
    end

    assign dmem_req_valid   = (state == ST_REQ);
    assign dmem_addr        = addr_q;
    assign dmem_we          = we_q;
    assign dmem_wstrb       = wstrb_q;
    assign dmem_wdata       = wdata_q;

    assign stall_out_MEM    = mem_go & (state != ST_DONE);
    // Non-memory and faulting instructions flow straight through without waiting.
    assign valid_out_MEM    = (state == ST_DONE) | (valid_in_MEM & ~mem_go);
    assign misalign_out_MEM = mem_op & misaligned;
    assign PCSrc_out_MEM    = valid_in_MEM & Branch_in_MEM & zero_in_MEM;
    assign Data_out_MEM     = data_q;
    assign ALU_out_out_MEM  = ALU_out_in_MEM;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed checks of the MEM stage: store/load timing, lane alignment, misalign, stall, reset, branch.
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_MEM, MemRead_in_MEM, MemWrite_in_MEM, Branch_in_MEM, zero_in_MEM;
    logic [31:0] ALU_out_in_MEM, Rs2_in_MEM;
    logic [2:0]  funct3_in_MEM;
    logic        PCSrc_out_MEM, stall_out_MEM, valid_out_MEM, misalign_out_MEM;
    logic [31:0] Data_out_MEM, ALU_out_out_MEM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in_MEM(valid_in_MEM), .ALU_out_in_MEM(ALU_out_in_MEM), .Rs2_in_MEM(Rs2_in_MEM),
        .MemRead_in_MEM(MemRead_in_MEM), .MemWrite_in_MEM(MemWrite_in_MEM),
        .funct3_in_MEM(funct3_in_MEM), .Branch_in_MEM(Branch_in_MEM), .zero_in_MEM(zero_in_MEM),
        .PCSrc_out_MEM(PCSrc_out_MEM), .stall_out_MEM(stall_out_MEM), .valid_out_MEM(valid_out_MEM),
        .Data_out_MEM(Data_out_MEM), .ALU_out_out_MEM(ALU_out_out_MEM),
        .misalign_out_MEM(misalign_out_MEM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
    );

    // Inputs change 2 time units after the edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        valid_in_MEM = 0; MemRead_in_MEM = 0; MemWrite_in_MEM = 0;
        Branch_in_MEM = 0; zero_in_MEM = 0; funct3_in_MEM = 3'b000;
        ALU_out_in_MEM = 32'h0; Rs2_in_MEM = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1; clear_in();
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 32'h0;
        step(); step();
        n_chk++; if (dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %0h exp 0", dmem_req_valid); end
        n_chk++; if (stall_out_MEM !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0h exp 0", stall_out_MEM); end
        n_chk++; if (valid_out_MEM !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out got %0h exp 0", valid_out_MEM); end
        n_chk++; if (Data_out_MEM !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h exp 0", Data_out_MEM); end
        n_chk++; if (dmem_wstrb !== 4'h0) begin n_fail++; $display("FAIL rst_wstrb got %h exp 0", dmem_wstrb); end
        rst = 0;
        step();
    endtask

    task automatic test_sw();
        dmem_req_ready = 1;
        valid_in_MEM = 1; MemWrite_in_MEM = 1; funct3_in_MEM = 3'b010;
        ALU_out_in_MEM = 32'h10; Rs2_in_MEM = 32'hDEADBEEF;
        #1;
        n_chk++; if (stall_out_MEM !== 1'b1) begin n_fail++; $display("FAIL sw_c0_stall got %0h exp 1", stall_out_MEM); end
        n_chk++; if (valid_out_MEM !== 1'b0) begin n_fail++; $display("FAIL sw_c0_valid got %0h exp 0", valid_out_MEM); end
        n_chk++; if (dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL sw_c0_req got %0h exp 0", dmem_req_valid); end
        n_chk++; if (ALU_out_out_MEM !== 32'h10) begin n_fail++; $display("FAIL sw_alu_pass got %h exp 10", ALU_out_out_MEM); end
        step();
        n_chk++; if (dmem_req_valid !== 1'b1) begin n_fail++; $display("FAIL sw_c1_req got %0h exp 1", dmem_req_valid); end
        n_chk++; if (dmem_addr !== 32'h10) begin n_fail++; $display("FAIL sw_addr got %h exp 10", dmem_addr); end
        n_chk++; if (dmem_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb got %b exp 1111", dmem_wstrb); end
        n_chk++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sw_we got %0h exp 1", dmem_we); end
        n_chk++; if (dmem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h exp deadbeef", dmem_wdata); end
        n_chk++; if (stall_out_MEM !== 1'b1) begin n_fail++; $display("FAIL sw_c1_stall got %0h exp 1", stall_out_MEM); end
        step();
        n_chk++; if (valid_out_MEM !== 1'b1) begin n_fail++; $display("FAIL sw_c2_valid got %0h exp 1", valid_out_MEM); end
        n_chk++; if (stall_out_MEM !== 1'b0) begin n_fail++; $display("FAIL sw_c2_stall got %0h exp 0", stall_out_MEM); end
        n_chk++; if (dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL sw_c2_req got %0h exp 0", dmem_req_valid); end
        clear_in();
        step();
        n_chk++; if (valid_out_MEM !== 1'b0) begin n_fail++; $display("FAIL sw_c3_valid got %0h exp 0", valid_out_MEM); end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] exp);
        dmem_req_ready = 1;
        valid_in_MEM = 1; MemRead_in_MEM = 1; funct3_in_MEM = f3;
        ALU_out_in_MEM = 32'h13;
        step();
        n_chk++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_req got v%0h we%0h exp v1 we0", dmem_req_valid, dmem_we); end
        n_chk++; if (dmem_addr !== 32'h10) begin n_fail++; $display("FAIL ld_addr got %h exp 10", dmem_addr); end
        n_chk++; if (dmem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL ld_wstrb got %b exp 0000", dmem_wstrb); end
        step();
        n_chk++; if (stall_out_MEM !== 1'b1 || valid_out_MEM !== 1'b0) begin n_fail++; $display("FAIL ld_wait got stall%0h valid%0h exp stall1 valid0", stall_out_MEM, valid_out_MEM); end
        dmem_rsp_valid = 1; dmem_rdata = 32'h80FF0000;
        step();
        dmem_rsp_valid = 0; dmem_rdata = 32'h0;
        n_chk++; if (Data_out_MEM !== exp) begin n_fail++; $display("FAIL ld_data f3=%0d got %h exp %h", f3, Data_out_MEM, exp); end
        n_chk++; if (valid_out_MEM !== 1'b1 || stall_out_MEM !== 1'b0) begin n_fail++; $display("FAIL ld_done got valid%0h stall%0h exp valid1 stall0", valid_out_MEM, stall_out_MEM); end
        clear_in();
        step();
        n_chk++; if (valid_out_MEM !== 1'b0) begin n_fail++; $display("FAIL ld_valid_once got %0h exp 0", valid_out_MEM); end
        n_chk++; if (Data_out_MEM !== exp) begin n_fail++; $display("FAIL ld_data_hold got %h exp %h", Data_out_MEM, exp); end
    endtask

    task automatic test_sh();
        dmem_req_ready = 1;
        valid_in_MEM = 1; MemWrite_in_MEM = 1; funct3_in_MEM = 3'b001;
        ALU_out_in_MEM = 32'h06; Rs2_in_MEM = 32'h1234ABCD;
        step();
        n_chk++; if (dmem_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb got %b exp 1100", dmem_wstrb); end
        n_chk++; if (dmem_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", dmem_wdata); end
        n_chk++; if (dmem_addr !== 32'h04) begin n_fail++; $display("FAIL sh_addr got %h exp 04", dmem_addr); end
        step();
        clear_in();
        step();
        // SB to byte 1 exercises the byte shift and replication.
        valid_in_MEM = 1; MemWrite_in_MEM = 1; funct3_in_MEM = 3'b000;
        ALU_out_in_MEM = 32'h21; Rs2_in_MEM = 32'h000000A5;
        step();
        n_chk++; if (dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_lane got %b/%h exp 0010/a5a5a5a5", dmem_wstrb, dmem_wdata); end
        step();
        clear_in();
        step();
    endtask

    task automatic test_misalign();
        valid_in_MEM = 1; MemRead_in_MEM = 1; funct3_in_MEM = 3'b010;
        ALU_out_in_MEM = 32'h02;
        #1;
        n_chk++; if (misalign_out_MEM !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %0h exp 1", misalign_out_MEM); end
        n_chk++; if (valid_out_MEM !== 1'b1 || stall_out_MEM !== 1'b0) begin n_fail++; $display("FAIL mis_flow got valid%0h stall%0h exp valid1 stall0", valid_out_MEM, stall_out_MEM); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_req cyc%0d got %0h exp 0", i, dmem_req_valid); end
        end
        clear_in();
        step();
    endtask

    task automatic test_stall_and_reset();
        dmem_req_ready = 0;
        valid_in_MEM = 1; MemWrite_in_MEM = 1; funct3_in_MEM = 3'b010;
        ALU_out_in_MEM = 32'h20; Rs2_in_MEM = 32'h11223344;
        step();
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h20 || dmem_wdata !== 32'h11223344 || stall_out_MEM !== 1'b1)
                begin n_fail++; $display("FAIL hold cyc%0d got v%0h a%h d%h s%0h exp v1 a20 d11223344 s1", i, dmem_req_valid, dmem_addr, dmem_wdata, stall_out_MEM); end
            step();
        end
        dmem_req_ready = 1;
        step();
        n_chk++; if (valid_out_MEM !== 1'b1) begin n_fail++; $display("FAIL hold_done got %0h exp 1", valid_out_MEM); end
        clear_in();
        step();
        valid_in_MEM = 1; MemRead_in_MEM = 1; funct3_in_MEM = 3'b010; ALU_out_in_MEM = 32'h08;
        step();
        step();
        rst = 1; clear_in();
        step();
        n_chk++; if (dmem_req_valid !== 1'b0 || stall_out_MEM !== 1'b0) begin n_fail++; $display("FAIL rstw got req%0h stall%0h exp 0 0", dmem_req_valid, stall_out_MEM); end
        rst = 0;
        dmem_rsp_valid = 1; dmem_rdata = 32'hAAAAAAAA;
        step();
        dmem_rsp_valid = 0;
        n_chk++; if (Data_out_MEM !== 32'h0 || valid_out_MEM !== 1'b0) begin n_fail++; $display("FAIL late_rsp got data%h valid%0h exp 0 0", Data_out_MEM, valid_out_MEM); end
    endtask

    task automatic test_branch();
        valid_in_MEM = 1; Branch_in_MEM = 1; zero_in_MEM = 1;
        #1;
        n_chk++; if (PCSrc_out_MEM !== 1'b1) begin n_fail++; $display("FAIL br_taken got %0h exp 1", PCSrc_out_MEM); end
        n_chk++; if (stall_out_MEM !== 1'b0 || dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL br_nostall got s%0h r%0h exp 0 0", stall_out_MEM, dmem_req_valid); end
        zero_in_MEM = 0;
        #1;
        n_chk++; if (PCSrc_out_MEM !== 1'b0) begin n_fail++; $display("FAIL br_not_taken got %0h exp 0", PCSrc_out_MEM); end
        step();
        n_chk++; if (dmem_req_valid !== 1'b0 || valid_out_MEM !== 1'b1) begin n_fail++; $display("FAIL br_flow got r%0h v%0h exp 0 1", dmem_req_valid, valid_out_MEM); end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_sw();
        test_load(3'b000, 32'hFFFFFF80);
        test_load(3'b100, 32'h00000080);
        test_sh();
        test_misalign();
        test_stall_and_reset();
        test_branch();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
